// File: rtl/round_robin_pkg.sv
// Shared round-robin index types, reused by the arbiter and the distributor.
package round_robin_pkg;

    // Index of one of two ports (output slot or requester grant).
    typedef logic rr_idx_t;

    // Pointer value after reset: port 0 is first in line.
    localparam rr_idx_t RR_PTR_RESET = 1'b0;

    // The other port of a pair.
    function automatic rr_idx_t rr_other(input rr_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/distributor_slot.sv
// One-entry output register: loads a word, drains it on a downstream transfer.
module distributor_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A load wins over a drain, so drain+load in one cycle keeps the slot full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_in;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/round_robin_distributor_with_2_outputs.sv
// Fans one valid/ready stream out to two registered output slots in round-robin order.
module round_robin_distributor_with_2_outputs
    import round_robin_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit STRICT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic [1:0]       down_valid,
    input  logic [1:0]       down_ready,
    output logic [WIDTH-1:0] down_data_0,
    output logic [WIDTH-1:0] down_data_1,
    output logic             next_out
);

    rr_idx_t          ptr_q, ptr_d;
    rr_idx_t          target;
    logic             has_target;
    logic             accept;
    logic [1:0]       slot_free;
    logic [1:0]       slot_load;
    logic [1:0]       slot_drain;
    logic [WIDTH-1:0] slot_data [2];

    // A slot can take a word if it is empty or its consumer empties it this cycle.
    assign slot_free  = ~down_valid | down_ready;
    assign slot_drain = down_valid & down_ready;

    // Pick the pointed-to slot, or (work-conserving only) fall back to the other one.
    always_comb begin
        target     = ptr_q;
        has_target = 1'b0;
        if (slot_free[ptr_q]) begin
            target     = ptr_q;
            has_target = 1'b1;
        end else if (!STRICT && slot_free[rr_other(ptr_q)]) begin
            target     = rr_other(ptr_q);
            has_target = 1'b1;
        end
    end

    // up_ready depends only on slot state and down_ready, never on up_valid/up_data.
    assign up_ready = has_target;
    assign accept   = up_valid & has_target;
    assign ptr_d    = accept ? rr_other(target) : ptr_q;

    // Round-robin pointer: moves past the slot that just took a word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= RR_PTR_RESET;
        else      ptr_q <= ptr_d;
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        assign slot_load[i] = accept & (target == rr_idx_t'(i));

        distributor_slot #(.WIDTH(WIDTH)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (slot_load[i]),
            .drain   (slot_drain[i]),
            .data_in (up_data),
            .valid   (down_valid[i]),
            .data    (slot_data[i])
        );
    end

    assign down_data_0 = slot_data[0];
    assign down_data_1 = slot_data[1];
    assign next_out    = ptr_q;

endmodule

// File: tb/tb_round_robin_distributor_with_2_outputs.sv
// Directed, table-driven bench for the two-output round-robin distributor.
module tb_round_robin_distributor_with_2_outputs;

    typedef struct {
        logic       uv;
        logic [7:0] d;
        logic [1:0] dr;
        logic       rdy;
        logic [1:0] dv;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       nx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Work-conserving instance
    logic       a_uv = 1'b0, a_rdy, a_nx;
    logic [7:0] a_d = '0, a_d0, a_d1;
    logic [1:0] a_dr = '0, a_dv;

    // Strict-alternation instance
    logic       b_uv = 1'b0, b_rdy, b_nx;
    logic [7:0] b_d = '0, b_d0, b_d1;
    logic [1:0] b_dr = '0, b_dv;

    int n_chk = 0;
    int n_err = 0;

    vec_t t0[$];
    vec_t t1[$];

    always #5 clk = ~clk;

    round_robin_distributor_with_2_outputs #(.WIDTH(8), .STRICT(1'b0)) dut_wc (
        .clk(clk), .rst(rst), .up_valid(a_uv), .up_ready(a_rdy), .up_data(a_d),
        .down_valid(a_dv), .down_ready(a_dr), .down_data_0(a_d0), .down_data_1(a_d1),
        .next_out(a_nx)
    );

    round_robin_distributor_with_2_outputs #(.WIDTH(8), .STRICT(1'b1)) dut_st (
        .clk(clk), .rst(rst), .up_valid(b_uv), .up_ready(b_rdy), .up_data(b_d),
        .down_valid(b_dv), .down_ready(b_dr), .down_data_0(b_d0), .down_data_1(b_d1),
        .next_out(b_nx)
    );

    function automatic vec_t mk(logic uv, logic [7:0] d, logic [1:0] dr, logic rdy,
                                logic [1:0] dv, logic [7:0] d0, logic [7:0] d1, logic nx);
        vec_t v;
        v.uv = uv; v.d = d; v.dr = dr; v.rdy = rdy;
        v.dv = dv; v.d0 = d0; v.d1 = d1; v.nx = nx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at negedge, check up_ready before the edge, state just after it.
    task automatic run(input int w, input int idx, input vec_t v);
        string tag;
        tag = $sformatf("%s[%0d]", (w == 0) ? "wc" : "st", idx);
        @(negedge clk);
        if (w == 0) begin a_uv = v.uv; a_d = v.d; a_dr = v.dr; end
        else        begin b_uv = v.uv; b_d = v.d; b_dr = v.dr; end
        #1;
        chk({tag, ".up_ready"}, (w == 0) ? a_rdy : b_rdy, v.rdy);
        @(posedge clk);
        #1;
        chk({tag, ".down_valid"},  (w == 0) ? a_dv : b_dv, v.dv);
        chk({tag, ".down_data_0"}, (w == 0) ? a_d0 : b_d0, v.d0);
        chk({tag, ".down_data_1"}, (w == 0) ? a_d1 : b_d1, v.d1);
        chk({tag, ".next_out"},    (w == 0) ? a_nx : b_nx, v.nx);
    endtask

    initial begin
        //                uv  data   dr     rdy  dv     d0     d1     nx
        // Alternating stream, both consumers ready
        t0.push_back(mk(1, 8'hA1, 2'b11, 1, 2'b01, 8'hA1, 8'h00, 1));
        t0.push_back(mk(1, 8'hA2, 2'b11, 1, 2'b10, 8'hA1, 8'hA2, 0));
        t0.push_back(mk(1, 8'hA3, 2'b11, 1, 2'b01, 8'hA3, 8'hA2, 1));
        t0.push_back(mk(1, 8'hA4, 2'b11, 1, 2'b10, 8'hA3, 8'hA4, 0));
        // Fill slot 0 so both are full with the pointer at 1
        t0.push_back(mk(1, 8'h55, 2'b00, 1, 2'b11, 8'h55, 8'hA4, 1));
        // Slot 1 stalled: everything goes to out0 at full rate, pointer stays 1
        t0.push_back(mk(1, 8'h10, 2'b01, 1, 2'b11, 8'h10, 8'hA4, 1));
        t0.push_back(mk(1, 8'h11, 2'b01, 1, 2'b11, 8'h11, 8'hA4, 1));
        t0.push_back(mk(1, 8'h12, 2'b01, 1, 2'b11, 8'h12, 8'hA4, 1));
        t0.push_back(mk(1, 8'h13, 2'b01, 1, 2'b11, 8'h13, 8'hA4, 1));
        // Both full, nobody ready: blocked and stable
        for (int i = 0; i < 5; i++)
            t0.push_back(mk(1, 8'hEE, 2'b00, 0, 2'b11, 8'h13, 8'hA4, 1));
        // Slot 1 drains and reloads in the same cycle
        t0.push_back(mk(1, 8'h77, 2'b10, 1, 2'b11, 8'h13, 8'h77, 0));
        // Empty both slots; data registers keep their last words
        t0.push_back(mk(0, 8'h00, 2'b11, 1, 2'b00, 8'h13, 8'h77, 0));
        // Input gaps 1,0,0,1,1: targets 0,1,0
        t0.push_back(mk(1, 8'hB1, 2'b11, 1, 2'b01, 8'hB1, 8'h77, 1));
        t0.push_back(mk(0, 8'hB2, 2'b11, 1, 2'b00, 8'hB1, 8'h77, 1));
        t0.push_back(mk(0, 8'hB2, 2'b11, 1, 2'b00, 8'hB1, 8'h77, 1));
        t0.push_back(mk(1, 8'hB3, 2'b11, 1, 2'b10, 8'hB1, 8'hB3, 0));
        t0.push_back(mk(1, 8'hB4, 2'b11, 1, 2'b01, 8'hB4, 8'hB3, 1));
        // Fill both slots ahead of the asynchronous reset
        t0.push_back(mk(1, 8'hC1, 2'b00, 1, 2'b11, 8'hB4, 8'hC1, 0));

        // Strict alternation: slot 1 stalled blocks input until it drains
        t1.push_back(mk(1, 8'h55, 2'b00, 1, 2'b01, 8'h55, 8'h00, 1));
        t1.push_back(mk(1, 8'h66, 2'b00, 1, 2'b11, 8'h55, 8'h66, 0));
        t1.push_back(mk(1, 8'h10, 2'b01, 1, 2'b11, 8'h10, 8'h66, 1));
        t1.push_back(mk(1, 8'h11, 2'b01, 0, 2'b10, 8'h10, 8'h66, 1));
        t1.push_back(mk(1, 8'h11, 2'b01, 0, 2'b10, 8'h10, 8'h66, 1));
        t1.push_back(mk(1, 8'h11, 2'b11, 1, 2'b10, 8'h10, 8'h11, 0));
        t1.push_back(mk(1, 8'h12, 2'b11, 1, 2'b01, 8'h12, 8'h11, 1));

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.down_valid", a_dv, 2'b00);
        chk("rst.next_out",   a_nx, 1'b0);
        chk("rst.up_ready",   a_rdy, 1'b1);
        chk("rst.down_data_0", a_d0, 8'h00);
        chk("rst.st_up_ready", b_rdy, 1'b1);
        @(negedge clk);
        rst = 1'b1;

        foreach (t0[i]) run(0, i, t0[i]);
        @(negedge clk);
        a_uv = 1'b0; a_dr = 2'b00;
        foreach (t1[i]) run(1, i, t1[i]);
        @(negedge clk);
        b_uv = 1'b0; b_dr = 2'b00;

        // Reach a both-full state in the work-conserving instance, then reset mid-cycle
        chk("pre_rst.down_valid", a_dv, 2'b11);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst.down_valid",  a_dv, 2'b00);
        chk("async_rst.next_out",    a_nx, 1'b0);
        chk("async_rst.down_data_0", a_d0, 8'h00);
        chk("async_rst.down_data_1", a_d1, 8'h00);
        chk("async_rst.up_ready",    a_rdy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        // First word after release goes to out0
        run(0, 99, mk(1, 8'hD1, 2'b11, 1, 2'b01, 8'hD1, 8'h00, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
